memory_stage: RTL and testbench
===============================

# memory_stage

Fourth stage of the in-order SimpleMIPS pipeline. Sits between the execute stage and `writeback_stage`. Holds one instruction and waits for its data-memory response. Performs load byte/halfword alignment and merging, and presents the finished result on the MEM→WB bus and the MEM forward bus. It also drops memory responses that belong to instructions killed by a writeback-stage exception or ERET flush.

## Interface
Parameters:
- `DISCARD_W`, default 2: width of the orphan-response discard counter; maximum tracked orphans is 2^DISCARD_W−1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock
- `resetn`  in  1  asynchronous active-low reset
- `es_to_ms_valid`  in  1  EX holds a valid instruction for MEM
- `es_to_ms_bus`  in  `es_to_ms_bus_t`  pc, dest, rf_we[3:0], load_op (LB/LBU/LH/LHU/LW/LWL/LWR/none), addr_lo[1:0], rt_value, result, mem_req (request issued in EX), exception, c0/tlb/cache fields
- `es_req_inflight`  in  1  EX has issued a data request whose instruction has not entered MEM
- `ms_allowin`  out  1  MEM accepts a new instruction this cycle
- `ws_allowin`  in  1  WB accepts this cycle
- `ms_to_ws_bus`  out  `ms_to_ws_bus_t`  includes `.valid`, result replaced by the load value for loads
- `ms_forward_bus`  out  `ms_forward_bus_t`  {load_pending, rf_we[3:0], dest&{5{ms_valid}}, result}
- `data_data_ok`  in  1  data response strobe, in request order
- `data_rdata`  in  32  response data
- `flush`  in  1  `pipeline_flush.ex_en | pipeline_flush.eret_flush` from WB

## Operation
- State: `ms_valid`, `bus_r`, `buf_valid`, `rdata_buf[31:0]`, `discard_cnt[DISCARD_W-1:0]`.
- `need_data = bus_r.mem_req & ~|exception`.
- `got_data = buf_valid | (data_data_ok & discard_cnt==0)`.
- `ms_ready_go = ~need_data | got_data`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_bus.valid = ms_valid & ms_ready_go & ~flush`.
- Entry: when `ms_allowin & es_to_ms_valid & ~flush`, load `bus_r`, set `ms_valid`, clear `buf_valid`. When `ms_allowin` holds without entry, clear `ms_valid`.
- Buffering: if `data_data_ok` belongs to the current instruction and `ws_allowin`=0, capture `rdata_buf` and set `buf_valid`. Later data reads come from the buffer, never the live bus.
- Discard: every `data_data_ok` while `discard_cnt>0` is dropped and decrements the counter.
- On `flush`:
  - `ms_valid`←0 and `buf_valid`←0.
  - `discard_cnt` increases by (`need_data & ~got_data & ms_valid`) + `es_req_inflight`, minus 1 if a response is dropped that same cycle.
  - The counter saturates; reaching saturation is a design error flagged by an assertion.
- Load alignment, with raw = chosen data and a = addr_lo:
  - LW: raw.
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], extended.
  - LWL: merge raw left-shifted by 8·(3−a) with the low bytes of rt_value.
  - LWR: merge raw right-shifted by 8·a with the high bytes of rt_value.
  - rf_we is passed unchanged; EX already encodes byte enables for LWL/LWR.
- Non-loads pass `result` through.
- `load_pending = ms_valid & need_data & ~got_data`. ID stalls on it.

## Timing
- Reset values:
  - registers: `ms_valid`=0, `buf_valid`=0, `discard_cnt`=0, `bus_r`=0.
  - outputs: `ms_allowin`=1, `ms_to_ws_bus.valid`=0, forward dest=0, `load_pending`=0.
- Non-load latency: 1 cycle. MEM→WB transfers the cycle after entry if `ws_allowin`.
- `data_data_ok` feeds `ms_ready_go` and the result combinationally. A response in cycle N transfers to WB in cycle N.
- Simultaneous events:
  - flush plus entry: flush wins and nothing enters.
  - flush plus the current instruction's response: the response is consumed with no counter increment.
  - flush plus a dropped response: net counter change as above.
- `resetn` deassertion mid-operation clears everything asynchronously. Responses to requests issued before reset are the memory side's responsibility.

## Test plan
- LW at addr 0x100, `data_data_ok` 3 cycles later with 0x8899AABB, `ws_allowin`=1 → `load_pending` for 3 cycles, then `ms_to_ws_bus.result`=0x8899AABB with valid for exactly 1 cycle.
- LB a=2 and LBU a=2 with data 0x00F30000; LH a=2 with data 0x80010000 → 0xFFFFFFF3, 0x000000F3, 0xFFFF8001.
- LWL a=1 and LWR a=1 with rt 0x11223344 and data 0xAABBCCDD → 0xCCDD3344 and 0x11AABBCC.
- Response arrives while `ws_allowin`=0 for 4 cycles, bus data changes afterward → WB receives the buffered value, not the later bus value.
- `flush` with a pending load in MEM and `es_req_inflight`=1 → `discard_cnt`=2. The next two responses (0xDEAD, 0xBEEF) are dropped. A new LW then receives the third response.
- Non-load ADD result 0x5 with `ws_allowin` toggling 0,1 → held stable, transfers once, `ms_allowin` follows `ws_allowin`.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: fourth stage of the SimpleMIPS pipeline.
// Holds one instruction, waits for its data response, aligns/merges load
// data and drops responses that belong to instructions killed by a flush.

package memory_stage_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_LWL  = 3'd6,
    LOAD_LWR  = 3'd7
  } load_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    load_op_t    load_op;
    logic [1:0]  addr_lo;
    logic [31:0] rt_value;
    logic [31:0] result;
    logic        mem_req;
    logic [5:0]  exception;
    logic [15:0] c0_info;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [5:0]  exception;
    logic [15:0] c0_info;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        load_pending;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_forward_bus_t;

endpackage

// Checker: the orphan-response counter must never reach its ceiling.
module memory_stage_sva #(
  parameter int DISCARD_W = 2
) (
  input logic                 clk,
  input logic                 resetn,
  input logic [DISCARD_W-1:0] discard_cnt
);
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = {DISCARD_W{1'b1}};

  no_discard_saturation: assert property (@(posedge clk) disable iff (!resetn)
    discard_cnt != DISCARD_MAX);
endmodule

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            es_to_ms_valid,
  input  es_to_ms_bus_t   es_to_ms_bus,
  input  logic            es_req_inflight,
  output logic            ms_allowin,
  input  logic            ws_allowin,
  output ms_to_ws_bus_t   ms_to_ws_bus,
  output ms_forward_bus_t ms_forward_bus,
  input  logic            data_data_ok,
  input  logic [31:0]     data_rdata,
  input  logic            flush
);

  localparam logic [DISCARD_W-1:0] DISCARD_MAX  = {DISCARD_W{1'b1}};
  localparam logic [DISCARD_W-1:0] DISCARD_ZERO = {DISCARD_W{1'b0}};

  logic                 ms_valid;
  es_to_ms_bus_t        bus_r;
  logic                 buf_valid;
  logic [31:0]          rdata_buf;
  logic [DISCARD_W-1:0] discard_cnt;

  logic                 need_data;
  logic                 got_data;
  logic                 ms_ready_go;
  logic                 resp_live;
  logic                 resp_drop;
  logic                 capture;
  logic                 pend_kill;
  logic                 inflight_kill;
  logic [31:0]          raw_data;
  logic [31:0]          final_result;
  logic [DISCARD_W+1:0] cnt_sum;
  logic [DISCARD_W-1:0] cnt_next;

  // Load alignment: extract/extend bytes and halfwords, merge LWL/LWR with rt.
  function automatic logic [31:0] align_load(input load_op_t op, input logic [1:0] a,
                                             input logic [31:0] raw, input logic [31:0] rt,
                                             input logic [31:0] res);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh_l;
    logic [4:0]  sh_r;
    logic [31:0] v;
    b    = raw[{a, 3'b000} +: 8];
    h    = raw[{a[1], 4'b0000} +: 16];
    sh_l = {~a, 3'b000};
    sh_r = {a, 3'b000};
    case (op)
      LOAD_LB:  v = {{24{b[7]}}, b};
      LOAD_LBU: v = {24'h000000, b};
      LOAD_LH:  v = {{16{h[15]}}, h};
      LOAD_LHU: v = {16'h0000, h};
      LOAD_LW:  v = raw;
      LOAD_LWL: v = (raw << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      LOAD_LWR: v = (raw >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
      default:  v = res;
    endcase
    return v;
  endfunction

  // A response with an empty discard counter belongs to the instruction in MEM.
  assign resp_live   = data_data_ok & (discard_cnt == DISCARD_ZERO);
  assign resp_drop   = data_data_ok & (discard_cnt != DISCARD_ZERO);
  assign need_data   = bus_r.mem_req & ~(|bus_r.exception);
  assign got_data    = buf_valid | resp_live;
  assign ms_ready_go = ~need_data | got_data;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign capture     = ms_valid & need_data & ~buf_valid & resp_live & ~ws_allowin;
  assign raw_data    = buf_valid ? rdata_buf : data_rdata;

  // Requests that lose their owner on a flush become orphans to be dropped.
  assign pend_kill     = flush & ms_valid & need_data & ~got_data;
  assign inflight_kill = flush & es_req_inflight;

  // Final result: load value for loads, EX result otherwise.
  always_comb begin
    final_result = align_load(bus_r.load_op, bus_r.addr_lo, raw_data, bus_r.rt_value,
                              bus_r.result);
  end

  // Next orphan count, clamped at the ceiling.
  always_comb begin
    cnt_sum = {2'b00, discard_cnt}
            + {{(DISCARD_W+1){1'b0}}, pend_kill}
            + {{(DISCARD_W+1){1'b0}}, inflight_kill}
            - {{(DISCARD_W+1){1'b0}}, resp_drop};
    if (cnt_sum > {2'b00, DISCARD_MAX}) begin
      cnt_next = DISCARD_MAX;
    end else begin
      cnt_next = cnt_sum[DISCARD_W-1:0];
    end
  end

  // Stage occupancy, instruction register and response buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      bus_r     <= '0;
      buf_valid <= 1'b0;
      rdata_buf <= 32'h0000_0000;
    end else if (flush) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid  <= es_to_ms_valid;
      buf_valid <= 1'b0;
      if (es_to_ms_valid) begin
        bus_r <= es_to_ms_bus;
      end
    end else if (capture) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_rdata;
    end
  end

  // Orphan-response counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt <= DISCARD_ZERO;
    end else begin
      discard_cnt <= cnt_next;
    end
  end

  assign ms_to_ws_bus.valid     = ms_valid & ms_ready_go & ~flush;
  assign ms_to_ws_bus.pc        = bus_r.pc;
  assign ms_to_ws_bus.dest      = bus_r.dest;
  assign ms_to_ws_bus.rf_we     = bus_r.rf_we;
  assign ms_to_ws_bus.result    = final_result;
  assign ms_to_ws_bus.exception = bus_r.exception;
  assign ms_to_ws_bus.c0_info   = bus_r.c0_info;

  assign ms_forward_bus.load_pending = ms_valid & need_data & ~got_data;
  assign ms_forward_bus.rf_we        = bus_r.rf_we;
  assign ms_forward_bus.dest         = bus_r.dest & {5{ms_valid}};
  assign ms_forward_bus.result       = final_result;

  memory_stage_sva #(.DISCARD_W(DISCARD_W)) u_sva (
    .clk         (clk),
    .resetn      (resetn),
    .discard_cnt (discard_cnt)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases from the test plan plus randomized
// traffic checked against a request-queue model of the memory system.

module tb_memory_stage;
  import memory_stage_pkg::*;

  logic            clk = 1'b0;
  logic            resetn;
  logic            es_to_ms_valid;
  es_to_ms_bus_t   es_to_ms_bus;
  logic            es_req_inflight;
  logic            ms_allowin;
  logic            ws_allowin;
  ms_to_ws_bus_t   ms_to_ws_bus;
  ms_forward_bus_t ms_forward_bus;
  logic            data_data_ok;
  logic [31:0]     data_rdata;
  logic            flush;

  memory_stage #(.DISCARD_W(2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_req_inflight (es_req_inflight),
    .ms_allowin      (ms_allowin),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_forward_bus  (ms_forward_bus),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: outstanding requests in issue order (tag = instruction id, -1 = orphan)
  int            req_q[$];
  bit            m_occ;
  es_to_ms_bus_t m_ins;
  int            m_id;
  bit            m_has;
  logic [31:0]   m_data;
  bit            ex_have;
  es_to_ms_bus_t ex_ins;
  int            ex_id;
  int            next_id = 0;

  logic          s_valid, s_lp, s_allow;
  logic [31:0]   s_result;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit needs(es_to_ms_bus_t b);
    return b.mem_req && (b.exception == 6'd0);
  endfunction

  function automatic es_to_ms_bus_t mk(load_op_t op, logic [1:0] a, logic [31:0] rt,
                                       logic [31:0] res, logic mreq, logic [5:0] exc);
    es_to_ms_bus_t b;
    b.pc        = $urandom;
    b.dest      = 5'($urandom_range(1, 31));
    b.rf_we     = (op == LOAD_NONE) ? 4'($urandom) : 4'hF;
    b.load_op   = op;
    b.addr_lo   = a;
    b.rt_value  = rt;
    b.result    = res;
    b.mem_req   = mreq;
    b.exception = exc;
    b.c0_info   = 16'($urandom);
    return b;
  endfunction

  // What WB must receive, from the architectural meaning of each load.
  function automatic logic [31:0] model_result(es_to_ms_bus_t ins, logic [31:0] raw);
    logic [7:0] rb[4];
    logic [7:0] tb[4];
    logic [7:0] ob[4];
    int ai, v, k;
    ai = int'(ins.addr_lo);
    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'(raw >> (8 * i));
      tb[i] = 8'(ins.rt_value >> (8 * i));
      ob[i] = tb[i];
    end
    case (ins.load_op)
      LOAD_LB, LOAD_LBU: begin
        v = int'(rb[ai]);
        if (ins.load_op == LOAD_LB && v >= 128) v -= 256;
        return 32'(v);
      end
      LOAD_LH, LOAD_LHU: begin
        k = (ai / 2) * 2;
        v = int'(rb[k]) + 256 * int'(rb[k+1]);
        if (ins.load_op == LOAD_LH && v >= 32768) v -= 65536;
        return 32'(v);
      end
      LOAD_LW: return raw;
      LOAD_LWL: for (int i = 0; i < 4; i++) if (i >= 3 - ai) ob[i] = rb[i-(3-ai)];
      LOAD_LWR: for (int i = 0; i < 4; i++) if (i <= 3 - ai) ob[i] = rb[i+ai];
      default: return ins.result;
    endcase
    return {ob[3], ob[2], ob[1], ob[0]};
  endfunction

  // EX issues its request as soon as it holds a memory instruction.
  task automatic present(es_to_ms_bus_t ins);
    ex_ins  = ins;
    ex_have = 1'b1;
    ex_id   = next_id++;
    if (needs(ins)) req_q.push_back(ex_id);
  endtask

  // One cycle: drive EX side, compare at negedge, advance model at posedge.
  task automatic step();
    bit resp_mine, need, got, rg, e_valid, e_allow, e_lp;
    logic [31:0] e_res;
    int head;
    es_to_ms_valid  = ex_have;
    es_to_ms_bus    = ex_ins;
    es_req_inflight = ex_have && needs(ex_ins);
    @(negedge clk);
    resp_mine = data_data_ok && (req_q.size() > 0) && m_occ && (req_q[0] == m_id);
    need      = m_occ && needs(m_ins);
    got       = m_has || resp_mine;
    rg        = !need || got;
    e_valid   = m_occ && rg && !flush;
    e_allow   = !m_occ || (rg && ws_allowin);
    e_lp      = need && !got;
    e_res     = model_result(m_ins, m_has ? m_data : data_rdata);
    chk("allowin", 32'(ms_allowin), 32'(e_allow));
    chk("valid", 32'(ms_to_ws_bus.valid), 32'(e_valid));
    chk("load_pending", 32'(ms_forward_bus.load_pending), 32'(e_lp));
    chk("fwd_dest", 32'(ms_forward_bus.dest), m_occ ? 32'(m_ins.dest) : 32'd0);
    if (m_occ) chk("fwd_rf_we", 32'(ms_forward_bus.rf_we), 32'(m_ins.rf_we));
    if (e_valid) begin
      chk("result", ms_to_ws_bus.result, e_res);
      chk("fwd_result", ms_forward_bus.result, e_res);
      chk("wb_pc", ms_to_ws_bus.pc, m_ins.pc);
      chk("wb_dest", 32'(ms_to_ws_bus.dest), 32'(m_ins.dest));
      chk("wb_rf_we", 32'(ms_to_ws_bus.rf_we), 32'(m_ins.rf_we));
    end
    s_valid  = ms_to_ws_bus.valid;
    s_lp     = ms_forward_bus.load_pending;
    s_allow  = ms_allowin;
    s_result = ms_to_ws_bus.result;
    if (data_data_ok && req_q.size() > 0) begin
      head = req_q.pop_front();
      if (m_occ && head == m_id) begin
        m_has  = 1'b1;
        m_data = data_rdata;
      end
    end
    if (flush) begin
      foreach (req_q[i]) req_q[i] = -1;
      m_occ   = 1'b0;
      m_has   = 1'b0;
      ex_have = 1'b0;
    end else if (e_allow) begin
      if (ex_have) begin
        m_occ   = 1'b1;
        m_ins   = ex_ins;
        m_id    = ex_id;
        m_has   = 1'b0;
        ex_have = 1'b0;
      end else begin
        m_occ = 1'b0;
        m_has = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    data_data_ok = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic run_load(string name, load_op_t op, logic [1:0] a, logic [31:0] rt,
                          logic [31:0] data, int delay, int stall, logic [31:0] exp);
    int lp_cycles = 0;
    present(mk(op, a, rt, 32'h0000_0100, 1'b1, 6'd0));
    ws_allowin = 1'b1;
    step();
    for (int i = 0; i < delay; i++) begin
      step();
      if (s_lp) lp_cycles++;
    end
    chk({name, "_pending_cycles"}, 32'(lp_cycles), 32'(delay));
    data_data_ok = 1'b1;
    data_rdata   = data;
    ws_allowin   = (stall == 0);
    step();
    for (int i = 1; i < stall; i++) begin
      ws_allowin = 1'b0;
      data_rdata = $urandom;
      step();
    end
    if (stall > 0) begin
      ws_allowin = 1'b1;
      data_rdata = ~data;
      step();
    end
    chk({name, "_valid"}, 32'(s_valid), 32'd1);
    chk({name, "_result"}, s_result, exp);
    step();
    chk({name, "_gone"}, 32'(s_valid), 32'd0);
  endtask

  function automatic es_to_ms_bus_t rand_ins();
    case ($urandom_range(0, 3))
      0: return mk(LOAD_NONE, 2'($urandom), $urandom, $urandom, 1'b0, 6'd0);
      1: return mk(LOAD_NONE, 2'($urandom), $urandom, $urandom, 1'b1, 6'd0);
      2: return mk(load_op_t'(3'($urandom_range(1, 7))), 2'($urandom), $urandom, $urandom,
                   1'b1, 6'd0);
      default: return mk(LOAD_NONE, 2'($urandom), $urandom, $urandom, 1'($urandom),
                         6'($urandom_range(1, 63)));
    endcase
  endfunction

  initial begin
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_req_inflight = 1'b0;
    ws_allowin = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0; flush = 1'b0;
    m_occ = 1'b0; m_ins = '0; m_id = -1; m_has = 1'b0; m_data = 32'h0;
    ex_have = 1'b0; ex_ins = '0; ex_id = -1;
    #2;
    chk("reset_allowin", 32'(ms_allowin), 32'd1);
    chk("reset_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    chk("reset_fwd_dest", 32'(ms_forward_bus.dest), 32'd0);
    chk("reset_load_pending", 32'(ms_forward_bus.load_pending), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    run_load("lw", LOAD_LW, 2'd0, 32'h1234_5678, 32'h8899_AABB, 3, 0, 32'h8899_AABB);
    run_load("lb", LOAD_LB, 2'd2, 32'h0, 32'h00F3_0000, 1, 0, 32'hFFFF_FFF3);
    run_load("lbu", LOAD_LBU, 2'd2, 32'h0, 32'h00F3_0000, 0, 0, 32'h0000_00F3);
    run_load("lh", LOAD_LH, 2'd2, 32'h0, 32'h8001_0000, 2, 0, 32'hFFFF_8001);
    run_load("lwl", LOAD_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 32'hCCDD_3344);
    run_load("lwr", LOAD_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 32'h11AA_BBCC);
    run_load("buffered", LOAD_LW, 2'd0, 32'h0, 32'hCAFE_F00D, 1, 4, 32'hCAFE_F00D);

    // Flush with a pending load in MEM and a request in flight from EX.
    present(mk(LOAD_LW, 2'd0, 32'h0, 32'h0, 1'b1, 6'd0));
    ws_allowin = 1'b1;
    step();
    step();
    present(mk(LOAD_LW, 2'd0, 32'h0, 32'h0, 1'b1, 6'd0));
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(s_valid), 32'd0);
    chk("flush_discard_cnt", 32'(dut.discard_cnt), 32'd2);
    present(mk(LOAD_LW, 2'd0, 32'h0, 32'h0, 1'b1, 6'd0));
    step();
    data_data_ok = 1'b1; data_rdata = 32'h0000_DEAD;
    step();
    chk("drop1_valid", 32'(s_valid), 32'd0);
    chk("drop1_pending", 32'(s_lp), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h0000_BEEF;
    step();
    chk("drop2_valid", 32'(s_valid), 32'd0);
    chk("drop2_discard_cnt", 32'(dut.discard_cnt), 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
    step();
    chk("after_drop_valid", 32'(s_valid), 32'd1);
    chk("after_drop_result", s_result, 32'h1357_9BDF);
    step();

    // Non-load held while WB stalls.
    present(mk(LOAD_NONE, 2'd0, 32'h0, 32'h0000_0005, 1'b0, 6'd0));
    step();
    ws_allowin = 1'b0;
    step();
    chk("alu_hold_valid", 32'(s_valid), 32'd1);
    chk("alu_hold_result", s_result, 32'h0000_0005);
    chk("alu_hold_allowin", 32'(s_allow), 32'd0);
    ws_allowin = 1'b1;
    step();
    chk("alu_go_valid", 32'(s_valid), 32'd1);
    chk("alu_go_result", s_result, 32'h0000_0005);
    chk("alu_go_allowin", 32'(s_allow), 32'd1);
    step();
    chk("alu_gone", 32'(s_valid), 32'd0);

    // Randomized traffic; flushes only when orphans stay below the ceiling.
    for (int c = 0; c < 4000; c++) begin
      if (!ex_have && $urandom_range(0, 2) != 0) present(rand_ins());
      ws_allowin = ($urandom_range(0, 9) < 7);
      data_rdata = $urandom;
      if (req_q.size() > 0 && (req_q[0] == -1 || (m_occ && req_q[0] == m_id)) &&
          $urandom_range(0, 9) < 4) data_data_ok = 1'b1;
      if ($urandom_range(0, 19) == 0 && (req_q.size() - int'(data_data_ok)) <= 2)
        flush = 1'b1;
      step();
    end

    // Asynchronous reset in the middle of a pending load.
    while (m_occ || ex_have || req_q.size() > 0) begin
      ws_allowin = 1'b1;
      if (req_q.size() > 0 && (req_q[0] == -1 || (m_occ && req_q[0] == m_id)))
        data_data_ok = 1'b1;
      step();
    end
    present(mk(LOAD_LW, 2'd0, 32'h0, 32'h0, 1'b1, 6'd0));
    step();
    step();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_allowin", 32'(ms_allowin), 32'd1);
    chk("async_reset_pending", 32'(ms_forward_bus.load_pending), 32'd0);
    chk("async_reset_fwd_dest", 32'(ms_forward_bus.dest), 32'd0);
    req_q.delete();
    m_occ = 1'b0; m_has = 1'b0; ex_have = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    run_load("post_reset_lbu", LOAD_LBU, 2'd3, 32'h0, 32'h9A00_0000, 1, 0, 32'h0000_009A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
